mult_bcd_feeder: RTL
====================

# mult_bcd_feeder

Sequential front end for the 8-digit seven-segment display driver. It latches two 4-bit operands on a start request and multiplies them with a 4-step shift-add datapath. It then converts the 8-bit product to three BCD digits using an 8-step double-dabble, and presents all eight 4-bit digit values ready to be wired straight onto the display driver's D0..D7 inputs.

## Interface
Parameters: none; operand width fixed at 4 bits, product 8 bits.

- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  4  multiplicand, unsigned
- b  input  4  multiplier, unsigned
- busy  output  1  high in MUL, CONV, DONE; low in IDLE
- done  output  1  one-cycle pulse; digit outputs valid and updated
- d0  output  4  product ones digit
- d1  output  4  product tens digit
- d2  output  4  product hundreds digit
- d3, d4, d5  output  4 each  constant 0
- d6  output  4  latched b (hex)
- d7  output  4  latched a (hex)

## Operation
- FSM states: IDLE, MUL, CONV, DONE.
- IDLE, start=1:
  - latch a, b into operand registers
  - clear the 8-bit product accumulator and the step counter
  - go to MUL
- IDLE, start=0: hold.
- MUL runs for 4 cycles, counter 0..3. Each step:
  - if multiplier LSB = 1, add the shifted multiplicand to the accumulator
  - shift the multiplicand left 1 and the multiplier right 1
  - after step 3, go to CONV
- CONV runs for 8 cycles, counter 0..7, using a 20-bit shift register {hundreds, tens, ones, binary}:
  - each step, add 3 to any BCD nibble ≥ 5, then shift left 1
  - after step 7, go to DONE
- Leaving CONV loads the digit registers in the same edge:
  - d0/d1/d2 take ones/tens/hundreds
  - d6/d7 take latched b/a
- DONE lasts 1 cycle; done=1 during it; next state IDLE.
- Arithmetic: unsigned. Max product 15×15 = 225, so the hundreds digit is ≤ 2 and no overflow is possible. The accumulator is 8 bits and never wraps.
- Digit outputs hold their last result until the next completion. They never show intermediate values.
- start while not in IDLE is ignored; no queuing.
- start held high: a new operation begins on the first edge back in IDLE, i.e. back-to-back operations with 1 IDLE cycle between.
- Operand changes after the start edge have no effect on the running operation.

## Timing
- Reset (reset=0, asynchronous):
  - state=IDLE, busy=0, done=0
  - d0..d7 = 0
  - counters and datapath cleared
- Release from reset is synchronous to the next clk edge.
- Reset mid-operation: immediate abort to the reset values above; no done pulse.
- Start sampled at edge T0:
  - busy rises after T0
  - MUL occupies cycles 1–4
  - CONV occupies cycles 5–12
  - done=1 and new digits valid in cycle 13 (after edge T0+13)
  - IDLE in cycle 14
- Throughput: one result per 14 cycles with start held high.
- done and the digit update are coincident; there is no cycle in which done=1 with stale digits.

## Configuration
- Macro MULT_BCD_HEX_EN.
- Defined:
  - CONV state and BCD datapath are compiled out; MUL goes directly to DONE
  - d0 = product[3:0], d1 = product[7:4], d2 = 0
  - done in cycle 5 after the start edge; throughput 6 cycles
- Undefined: decimal behaviour as specified above.

## Test plan
- Reset asserted mid-CONV -> busy=0, done=0, all digits 0 immediately (asynchronous); no done pulse follows; the next start works normally.
- a=15, b=15, start pulse -> done exactly 13 cycles after the start edge; d2,d1,d0 = 2,2,5; d7=F, d6=F; d3..d5 = 0.
- a=7, b=8 -> d2,d1,d0 = 0,5,6. Then a=0, b=9 -> all product digits 0; d7=0, d6=9.
- start pulsed again in cycle 3 and in DONE with different operands -> both ignored; result still reflects the first operands; only one done pulse.
- start held high with a=3, b=4 -> done pulses every 14 cycles; digits 0,1,2 each time; busy low for exactly 1 cycle between operations.
- MULT_BCD_HEX_EN defined, a=15, b=15 -> done in cycle 5; d1=E, d0=1, d2=0.

Source files
------------

// File: rtl/mult_bcd_feeder_if.sv
// mult_bcd_feeder_if: start/operand request and digit result bundle of mult_bcd_feeder
interface mult_bcd_feeder_if;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] d0, d1, d2, d3, d4, d5, d6, d7;
  modport master (output start, a, b, input busy, done, d0, d1, d2, d3, d4, d5, d6, d7);
  modport slave (input start, a, b, output busy, done, d0, d1, d2, d3, d4, d5, d6, d7);
endinterface

// File: rtl/mult_bcd_feeder.sv
// mult_bcd_feeder: 4x4 shift-add multiply then double-dabble to BCD digits for the display driver
// MULT_BCD_HEX_EN drops the BCD conversion and shows the product as two hex digits.
module mult_bcd_feeder (
  input logic clk,
  input logic reset,
  mult_bcd_feeder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, CONV, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] ra, rb, mp;
  logic [7:0] mc, acc, acc_nxt;
  logic [2:0] cnt;
  logic [3:0] q0, q1, q2, q6, q7;
  logic go, mul_last, fin;
`ifndef MULT_BCD_HEX_EN
  logic [19:0] sr, sr_adj, sr_nxt;
  logic conv_last;
  function automatic logic [3:0] adj(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
  assign sr_adj = {adj(sr[19:16]), adj(sr[15:12]), adj(sr[11:8]), sr[7:0]};
  assign sr_nxt = {sr_adj[18:0], 1'b0};
  assign conv_last = state == CONV && cnt == 3'd7;
  assign fin = conv_last;
`else
  assign fin = mul_last;
`endif
  assign acc_nxt = acc + (mp[0] ? mc : 8'd0);
  assign mul_last = state == MUL && cnt == 3'd3;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    go = 1'b0;
    case (state)
      IDLE: begin
        go = bus.start;
        state_nxt = bus.start ? MUL : IDLE;
      end
`ifndef MULT_BCD_HEX_EN
      MUL: state_nxt = mul_last ? CONV : MUL;
      CONV: state_nxt = conv_last ? DONE : CONV;
`else
      MUL: state_nxt = mul_last ? DONE : MUL;
      CONV: state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
    bus.busy = state != IDLE;
    bus.done = state == DONE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ra <= '0;
      rb <= '0;
      mp <= '0;
      mc <= '0;
      acc <= '0;
      cnt <= '0;
      {q0, q1, q2, q6, q7} <= '0;
`ifndef MULT_BCD_HEX_EN
      sr <= '0;
`endif
    end else begin
      if (go) begin
        ra <= bus.a;
        rb <= bus.b;
        mc <= {4'd0, bus.a};
        mp <= bus.b;
        acc <= '0;
        cnt <= '0;
      end
      if (state == MUL) begin
        acc <= acc_nxt;
        mc <= mc << 1;
        mp <= mp >> 1;
        cnt <= mul_last ? 3'd0 : cnt + 3'd1;
      end
`ifndef MULT_BCD_HEX_EN
      if (mul_last) sr <= {12'd0, acc_nxt};
      if (state == CONV) begin
        sr <= sr_nxt;
        cnt <= cnt + 3'd1;
      end
      if (fin) {q2, q1, q0} <= sr_nxt[19:8];
`else
      if (fin) {q2, q1, q0} <= {4'd0, acc_nxt};
`endif
      if (fin) {q7, q6} <= {ra, rb};
    end
  assign bus.d0 = q0;
  assign bus.d1 = q1;
  assign bus.d2 = q2;
  assign bus.d3 = 4'd0;
  assign bus.d4 = 4'd0;
  assign bus.d5 = 4'd0;
  assign bus.d6 = q6;
  assign bus.d7 = q7;
endmodule
